// File: rtl/ppu_layer_compositor.sv
// PPU pixel path: VGA raster timing, scaled game coordinates for the layer renderers,
// priority compositing with per-layer colour keys, and a maskable two-source interrupt unit.
module ppu_layer_compositor #(
  parameter int   NUM_LAYERS = 4,
  parameter int   RGB_BIT    = 12,
  parameter int   POS_BIT    = 10,
  parameter int   LAYER_LAT  = 2,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic                          clk_25p2MHz,
  input  logic                          rst,
  input  logic [1:0]                    scale_mode,
  input  logic [POS_BIT-1:0]            win_x,
  input  logic [POS_BIT-1:0]            win_y,
  input  logic [POS_BIT-1:0]            win_w,
  input  logic [POS_BIT-1:0]            win_h,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS*RGB_BIT-1:0] layer_key,
  input  logic [NUM_LAYERS*RGB_BIT-1:0] layer_rgb,
  input  logic [RGB_BIT-1:0]            bg_rgb,
  input  logic [RGB_BIT-1:0]            border_rgb,
  input  logic [POS_BIT-1:0]            irq_line,
  input  logic [1:0]                    irq_mask,
  input  logic [1:0]                    irq_ack,
  output logic [POS_BIT-1:0]            game_x,
  output logic [POS_BIT-1:0]            game_y,
  output logic                          game_win,
  output logic                          frame_start,
  output logic [1:0]                    irq_status,
  output logic                          irq,
  output logic                          hsync,
  output logic                          vsync,
  output logic [RGB_BIT-1:0]            rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [POS_BIT-1:0] H_LAST     = POS_BIT'(H_TOTAL - 1);
  localparam logic [POS_BIT-1:0] V_LAST     = POS_BIT'(V_TOTAL - 1);
  localparam logic [POS_BIT-1:0] H_ACT      = POS_BIT'(H_ACTIVE);
  localparam logic [POS_BIT-1:0] V_ACT      = POS_BIT'(V_ACTIVE);
  localparam logic [POS_BIT-1:0] H_ACT_LAST = POS_BIT'(H_ACTIVE - 1);
  localparam logic [POS_BIT-1:0] HS_START   = POS_BIT'(H_ACTIVE + H_FP);
  localparam logic [POS_BIT-1:0] HS_END     = POS_BIT'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_BIT-1:0] VS_START   = POS_BIT'(V_ACTIVE + V_FP);
  localparam logic [POS_BIT-1:0] VS_END     = POS_BIT'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [POS_BIT:0]   ONE_W      = (POS_BIT+1)'(1);

  logic [POS_BIT-1:0]   h_cnt_r, v_cnt_r;
  logic [1:0]           scale_sh_r, scale_eff_s, shift_s;
  logic [POS_BIT-1:0]   win_x_sh_r, win_y_sh_r, win_w_sh_r, win_h_sh_r;
  logic [POS_BIT-1:0]   wx_s, wy_s, ww_s, wh_s;
  logic [POS_BIT-1:0]   low_mask_s, gx_s, gy_s;
  logic [POS_BIT:0]     x_end_s, y_end_s;
  logic                 frame_origin_s, active_s, in_x_s, in_y_s, win_s, last_s;
  logic                 hs_s, vs_s, raster_s;
  logic [POS_BIT-1:0]   game_x_r, game_y_r;
  logic                 we_evt_r, frame_start_r;
  logic [LAYER_LAT:0]   act_pipe_r, win_pipe_r, hs_pipe_r, vs_pipe_r;
  logic [RGB_BIT-1:0]   pick_s, pix_s, rgb_r;
  logic                 hsync_r, vsync_r, irq_r;
  logic [1:0]           irq_status_r, status_next_s;

  assign frame_origin_s = (h_cnt_r == '0) && (v_cnt_r == '0);

  // Raster counters.
  always_ff @(posedge clk_25p2MHz) begin
    if (rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      v_cnt_r <= (v_cnt_r == V_LAST) ? '0 : v_cnt_r + POS_BIT'(1);
    end else begin
      h_cnt_r <= h_cnt_r + POS_BIT'(1);
    end
  end

  // Frame shadow of scale and window; capture at the frame origin.
  always_ff @(posedge clk_25p2MHz) begin
    if (rst) begin
      scale_sh_r <= 2'b00;
      win_x_sh_r <= '0;
      win_y_sh_r <= '0;
      win_w_sh_r <= '0;
      win_h_sh_r <= '0;
    end else if (frame_origin_s) begin
      scale_sh_r <= scale_mode;
      win_x_sh_r <= win_x;
      win_y_sh_r <= win_y;
      win_w_sh_r <= win_w;
      win_h_sh_r <= win_h;
    end else begin
      scale_sh_r <= scale_sh_r;
      win_x_sh_r <= win_x_sh_r;
      win_y_sh_r <= win_y_sh_r;
      win_w_sh_r <= win_w_sh_r;
      win_h_sh_r <= win_h_sh_r;
    end
  end

  // Stage-0 geometry: the origin pixel already uses the values being captured.
  always_comb begin
    if (frame_origin_s) begin
      scale_eff_s = scale_mode;
      wx_s = win_x; wy_s = win_y; ww_s = win_w; wh_s = win_h;
    end else begin
      scale_eff_s = scale_sh_r;
      wx_s = win_x_sh_r; wy_s = win_y_sh_r; ww_s = win_w_sh_r; wh_s = win_h_sh_r;
    end
    case (scale_eff_s)
      2'd1:    begin shift_s = 2'd1; low_mask_s = POS_BIT'(1); end
      2'd2:    begin shift_s = 2'd2; low_mask_s = POS_BIT'(3); end
      default: begin shift_s = 2'd0; low_mask_s = '0;          end
    endcase
    gx_s     = h_cnt_r >> shift_s;
    gy_s     = v_cnt_r >> shift_s;
    x_end_s  = {1'b0, wx_s} + {1'b0, ww_s};
    y_end_s  = {1'b0, wy_s} + {1'b0, wh_s};
    active_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    in_x_s   = ({1'b0, gx_s} >= {1'b0, wx_s}) && ({1'b0, gx_s} < x_end_s);
    in_y_s   = ({1'b0, gy_s} >= {1'b0, wy_s}) && ({1'b0, gy_s} < y_end_s);
    win_s    = active_s && in_x_s && in_y_s;
    last_s   = win_s && ({1'b0, gx_s} == x_end_s - ONE_W) && ({1'b0, gy_s} == y_end_s - ONE_W)
               && ((h_cnt_r & low_mask_s) == low_mask_s) && ((v_cnt_r & low_mask_s) == low_mask_s);
    hs_s     = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vs_s     = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    raster_s = (h_cnt_r == H_ACT_LAST) && (v_cnt_r == irq_line);
  end

  // Stage-0 outputs and the delay lines that meet the returning layer colours.
  always_ff @(posedge clk_25p2MHz) begin
    if (rst) begin
      game_x_r      <= '0;
      game_y_r      <= '0;
      we_evt_r      <= 1'b0;
      frame_start_r <= 1'b0;
      act_pipe_r    <= '0;
      win_pipe_r    <= '0;
      hs_pipe_r     <= '0;
      vs_pipe_r     <= '0;
    end else begin
      game_x_r      <= gx_s;
      game_y_r      <= gy_s;
      we_evt_r      <= last_s;
      frame_start_r <= frame_origin_s;
      act_pipe_r[0] <= active_s;
      win_pipe_r[0] <= win_s;
      hs_pipe_r[0]  <= hs_s;
      vs_pipe_r[0]  <= vs_s;
      for (int i = 1; i <= LAYER_LAT; i++) begin
        act_pipe_r[i] <= act_pipe_r[i-1];
        win_pipe_r[i] <= win_pipe_r[i-1];
        hs_pipe_r[i]  <= hs_pipe_r[i-1];
        vs_pipe_r[i]  <= vs_pipe_r[i-1];
      end
    end
  end

  // Priority select: scanning downward leaves the lowest opaque enabled layer.
  always_comb begin
    pick_s = bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i] && (layer_rgb[i*RGB_BIT +: RGB_BIT] != layer_key[i*RGB_BIT +: RGB_BIT])) begin
        pick_s = layer_rgb[i*RGB_BIT +: RGB_BIT];
      end else begin
        pick_s = pick_s;
      end
    end
    if (!act_pipe_r[LAYER_LAT]) begin
      pix_s = '0;
    end else if (!win_pipe_r[LAYER_LAT]) begin
      pix_s = border_rgb;
    end else begin
      pix_s = pick_s;
    end
  end

  // Interrupt status: new events take precedence over acknowledge.
  always_comb begin
    status_next_s[0] = we_evt_r | (irq_status_r[0] & ~irq_ack[0]);
    status_next_s[1] = raster_s | (irq_status_r[1] & ~irq_ack[1]);
  end

  // Registered pixel, sync and interrupt outputs.
  always_ff @(posedge clk_25p2MHz) begin
    if (rst) begin
      rgb_r        <= '0;
      hsync_r      <= ~SYNC_POL;
      vsync_r      <= ~SYNC_POL;
      irq_status_r <= 2'b00;
      irq_r        <= 1'b0;
    end else begin
      rgb_r        <= pix_s;
      hsync_r      <= hs_pipe_r[LAYER_LAT] ? SYNC_POL : ~SYNC_POL;
      vsync_r      <= vs_pipe_r[LAYER_LAT] ? SYNC_POL : ~SYNC_POL;
      irq_status_r <= status_next_s;
      irq_r        <= |(status_next_s & irq_mask);
    end
  end

  assign game_x      = game_x_r;
  assign game_y      = game_y_r;
  assign game_win    = win_pipe_r[0];
  assign frame_start = frame_start_r;
  assign irq_status  = irq_status_r;
  assign irq         = irq_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign rgb         = rgb_r;

endmodule

// File: tb/tb_ppu_layer_compositor.sv
// Directed bench for ppu_layer_compositor on a reduced 64x39 raster (48x32 active).
module tb_ppu_layer_compositor;

  localparam int HT = 64;

  logic        clk_25p2MHz = 1'b0;
  logic        rst;
  logic [1:0]  scale_mode;
  logic [9:0]  win_x, win_y, win_w, win_h;
  logic [3:0]  layer_en;
  logic [47:0] layer_key, layer_rgb;
  logic [11:0] bg_rgb, border_rgb;
  logic [9:0]  irq_line;
  logic [1:0]  irq_mask, irq_ack;
  logic [9:0]  game_x, game_y;
  logic        game_win, frame_start, irq, hsync, vsync;
  logic [1:0]  irq_status;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  ppu_layer_compositor #(
    .H_ACTIVE(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk_25p2MHz(clk_25p2MHz), .rst(rst), .scale_mode(scale_mode),
    .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
    .layer_en(layer_en), .layer_key(layer_key), .layer_rgb(layer_rgb),
    .bg_rgb(bg_rgb), .border_rgb(border_rgb), .irq_line(irq_line),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .game_x(game_x), .game_y(game_y),
    .game_win(game_win), .frame_start(frame_start), .irq_status(irq_status),
    .irq(irq), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk_25p2MHz = ~clk_25p2MHz;

  typedef struct {
    logic [1:0]  scale;
    logic [9:0]  wx, wy, ww, wh;
    logic [3:0]  en;
    logic [11:0] r0, r1, r2, r3, bg, border;
    int          px, py;
    logic [11:0] exp_rgb;
    logic        exp_win;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to just after edge n of the current frame (edge 0 loads counter (0,0)).
  task automatic goto(input int n);
    repeat (n - cur) @(posedge clk_25p2MHz);
    #1;
    cur = n;
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    @(negedge clk_25p2MHz);
    while (frame_start !== 1'b1 && k < 4000) begin
      @(negedge clk_25p2MHz);
      k++;
    end
    chk("frame_start_seen", int'(frame_start), 1);
    cur = 1;
  endtask

  function automatic logic act_of(input int sel);
    case (sel)
      0:       return !hsync;
      1:       return !vsync;
      default: return frame_start;
    endcase
  endfunction

  task automatic measure(input int sel, output int width, output int period);
    int  k;
    logic prev;
    width = -1; period = -1; k = 0;
    @(negedge clk_25p2MHz);
    prev = act_of(sel);
    while (k < 6000) begin
      @(negedge clk_25p2MHz);
      k++;
      if (act_of(sel) && !prev) break;
      prev = act_of(sel);
    end
    if (k < 6000) begin
      width = 0;
      while (act_of(sel) && width < 6000) begin
        width++;
        @(negedge clk_25p2MHz);
      end
      period = width;
      while (!act_of(sel) && period < 6000) begin
        period++;
        @(negedge clk_25p2MHz);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_game_x"}, int'(game_x), 0);
    chk({tag, "_game_y"}, int'(game_y), 0);
    chk({tag, "_game_win"}, int'(game_win), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_irq_status"}, int'(irq_status), 0);
    chk({tag, "_irq"}, int'(irq), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
  endtask

  initial begin
    int w, p, n;
    vecs[0]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hF, 12'h209, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 20, 20, 12'h0F0, 1'b1};
    vecs[1]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hF, 12'h209, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123,  2,  2, 12'h123, 1'b0};
    vecs[2]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hF, 12'h209, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 60,  2, 12'h000, 1'b0};
    vecs[3]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hF, 12'h209, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 39, 31, 12'h0F0, 1'b1};
    vecs[4]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hF, 12'h209, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 40, 20, 12'h123, 1'b0};
    vecs[5]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hF, 12'h209, 12'h000, 12'h333, 12'h444, 12'hABC, 12'h123, 20, 20, 12'hABC, 1'b1};
    vecs[6]  = '{2'd1, 10'd4, 10'd4, 10'd16, 10'd12, 4'hE, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 20, 20, 12'h0F0, 1'b1};
    vecs[7]  = '{2'd0, 10'd10, 10'd10, 10'd5, 10'd5, 4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 10, 10, 12'hF00, 1'b1};
    vecs[8]  = '{2'd0, 10'd10, 10'd10, 10'd5, 10'd5, 4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 15, 10, 12'h123, 1'b0};
    vecs[9]  = '{2'd2, 10'd2, 10'd2, 10'd4, 10'd4,   4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 23, 23, 12'hF00, 1'b1};
    vecs[10] = '{2'd2, 10'd2, 10'd2, 10'd4, 10'd4,   4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 24, 10, 12'h123, 1'b0};
    vecs[11] = '{2'd3, 10'd10, 10'd10, 10'd5, 10'd5, 4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123,  9, 10, 12'h123, 1'b0};
    vecs[12] = '{2'd3, 10'd10, 10'd10, 10'd5, 10'd5, 4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 14, 14, 12'hF00, 1'b1};
    vecs[13] = '{2'd0, 10'd10, 10'd10, 10'd0, 10'd5, 4'hF, 12'hF00, 12'h0F0, 12'h333, 12'h444, 12'hABC, 12'h123, 10, 10, 12'h123, 1'b0};

    rst = 1'b1; scale_mode = 2'd0;
    win_x = 10'd0; win_y = 10'd0; win_w = 10'd0; win_h = 10'd0;
    layer_en = 4'hF; layer_key = {12'h444, 12'h333, 12'h000, 12'h209};
    layer_rgb = {12'h444, 12'h333, 12'h000, 12'h209};
    bg_rgb = 12'hABC; border_rgb = 12'h123;
    irq_line = 10'd60; irq_mask = 2'b00; irq_ack = 2'b00;

    repeat (4) @(posedge clk_25p2MHz);
    #1;
    check_reset_values("por");
    rst = 1'b0;

    // Raster timing: sync widths and periods.
    measure(0, w, p);
    chk("hsync_low_width", w, 8);
    chk("hsync_period", p, 64);
    measure(1, w, p);
    chk("vsync_low_width", w, 128);
    chk("vsync_period", p, 2496);
    measure(2, w, p);
    chk("frame_start_width", w, 1);
    chk("frame_start_period", p, 2496);

    // Compositing vectors.
    for (int i = 0; i < 14; i++) begin
      scale_mode = vecs[i].scale;
      win_x = vecs[i].wx; win_y = vecs[i].wy; win_w = vecs[i].ww; win_h = vecs[i].wh;
      layer_en = vecs[i].en;
      layer_rgb = {vecs[i].r3, vecs[i].r2, vecs[i].r1, vecs[i].r0};
      bg_rgb = vecs[i].bg; border_rgb = vecs[i].border;
      wait_fs();
      n = vecs[i].py * HT + vecs[i].px;
      goto(n + 1);
      chk($sformatf("vec%0d_game_win", i), int'(game_win), int'(vecs[i].exp_win));
      goto(n + 4);
      chk($sformatf("vec%0d_rgb", i), int'(rgb), int'(vecs[i].exp_rgb));
    end

    // Frame A: raster irq, ack clear, masked window-end, mid-frame scale write.
    scale_mode = 2'd1; win_x = 10'd4; win_y = 10'd4; win_w = 10'd16; win_h = 10'd12;
    irq_line = 10'd10; irq_mask = 2'b10;
    wait_fs();
    goto(100);  irq_ack = 2'b11;
    goto(101);  irq_ack = 2'b00;
    goto(687);
    chk("raster_before_status", int'(irq_status[1]), 0);
    chk("raster_before_irq", int'(irq), 0);
    goto(688);
    chk("raster_set_status", int'(irq_status[1]), 1);
    chk("raster_set_irq", int'(irq), 1);
    goto(750);  irq_ack = 2'b10;
    goto(751);  irq_ack = 2'b00;
    chk("raster_ack_status", int'(irq_status[1]), 0);
    chk("raster_ack_irq", int'(irq), 0);
    goto(2024);
    chk("winend_before", int'(irq_status[0]), 0);
    goto(2025);
    chk("winend_set", int'(irq_status[0]), 1);
    chk("winend_masked_irq", int'(irq), 0);
    goto(2100); scale_mode = 2'd0;
    goto(2197);
    chk("midframe_game_x", int'(game_x), 10);
    chk("midframe_game_y", int'(game_y), 17);

    // Frame B: set and ack collide; new scale now in force.
    wait_fs();
    goto(687);
    chk("collide_pre_status", int'(irq_status[1]), 0);
    irq_ack = 2'b10;
    goto(688);
    irq_ack = 2'b00;
    chk("collide_status", int'(irq_status[1]), 1);
    chk("collide_irq", int'(irq), 1);
    goto(2197);
    chk("nextframe_game_x", int'(game_x), 20);
    chk("nextframe_game_y", int'(game_y), 34);

    // Frame C: reset at line 20 with pending flags; out-of-range line, empty window.
    win_w = 10'd0; irq_line = 10'd60; irq_mask = 2'b11;
    wait_fs();
    goto(20 * HT + 5);
    rst = 1'b1;
    @(posedge clk_25p2MHz); #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk_25p2MHz);
    #1;
    rst = 1'b0;
    @(posedge clk_25p2MHz); #1;
    cur = 1;
    chk("rst_restart_frame_start", int'(frame_start), 1);
    goto(6);
    chk("rst_restart_game_x", int'(game_x), 5);
    chk("rst_restart_game_y", int'(game_y), 0);
    goto(55);
    chk("hsync_before_start", int'(hsync), 1);
    goto(56);
    chk("hsync_at_start", int'(hsync), 0);
    goto(2179);
    chk("vsync_before_start", int'(vsync), 1);
    goto(2180);
    chk("vsync_at_start", int'(vsync), 0);
    wait_fs();
    goto(2400);
    chk("no_irq_status", int'(irq_status), 0);
    chk("no_irq", int'(irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_layer_compositor.md
Name:
ppu_layer_compositor

Overview:
- Parametrised successor to the PPU top-level pixel path.
- Generates VGA raster timing and broadcasts game-canvas coordinates (with 1x/2x/4x scaling) to NUM_LAYERS layer renderers.
- Composites the returned layer colours by priority with per-layer transparent colour keys, then drives aligned hsync/vsync/rgb.
- Contains a maskable two-source interrupt unit (game-window-end and programmable raster line) with write-1-to-clear acknowledge.

Parameters:
- NUM_LAYERS, 4: number of layer inputs; layer 0 has the highest priority.
- RGB_BIT, 12: colour width.
- POS_BIT, 10: coordinate width.
- LAYER_LAT, 2: cycles from game_x/game_y output to the matching layer_rgb sample.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixels.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines.
- SYNC_POL, 0: sync active level (0 = active-low).

Ports:
- clk_25p2MHz  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- scale_mode  in  2  0: 1x, 1: 2x, 2: 4x, 3: treated as 1x.
- win_x, win_y  in  POS_BIT each  game-window origin, in game coordinates.
- win_w, win_h  in  POS_BIT each  game-window size, in game coordinates.
- layer_en  in  NUM_LAYERS  per-layer enable.
- layer_key  in  NUM_LAYERS*RGB_BIT  per-layer transparent colour.
- layer_rgb  in  NUM_LAYERS*RGB_BIT  layer colours, valid LAYER_LAT cycles after game_x/game_y.
- bg_rgb  in  RGB_BIT  colour inside the window when all layers are transparent.
- border_rgb  in  RGB_BIT  colour in the active area outside the window.
- irq_line  in  POS_BIT  raster-interrupt screen line.
- irq_mask  in  2  bit0 = window-end, bit1 = raster.
- irq_ack  in  2  write-1-to-clear pulses.
- game_x, game_y  out  POS_BIT each  scaled coordinates to the layers.
- game_win  out  1  current coordinate is inside the window.
- frame_start  out  1  one-cycle pulse at h=0, v=0.
- irq_status  out  2  sticky interrupt flags.
- irq  out  1  |(irq_status & irq_mask).
- hsync, vsync  out  1 each  sync outputs.
- rgb  out  RGB_BIT  pixel output.

Behaviour:
- Counters: h_cnt runs 0..H_TOTAL-1, then wraps and advances v_cnt; v_cnt wraps at V_TOTAL-1.
  - Sync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for v_cnt.
- Shadow registers: scale_mode and win_* are captured at h=0, v=0 and used for the whole frame. Mid-frame changes have no effect until the next frame.
- Stage 0, registered (counter value at cycle t appears on outputs at t+1):
  - game_x = h_cnt >> s, game_y = v_cnt >> s, where s = 0, 1 or 2 per scale_mode.
  - game_win = active && game_x >= win_x && game_x < win_x+win_w (same test for y). Comparisons use POS_BIT+1 bits so win_x+win_w never wraps.
  - Outside the active area, game_x/game_y still follow the counters and game_win = 0.
- Layer sampling: layer_rgb is sampled at t+1+LAYER_LAT. The active, game_win and sync pipelines are delay-matched to this point.
- Compositing, registered, rgb valid at t+2+LAYER_LAT:
  - Not active: rgb = 0.
  - Active, outside the window: rgb = border_rgb.
  - Inside the window: rgb = the lowest-index layer with layer_en=1 and colour != its key.
  - Inside the window, no such layer: rgb = bg_rgb.
- hsync and vsync are delayed by the same 2+LAYER_LAT cycles as rgb, so all three stay aligned.
- Interrupts:
  - Window-end event: the cycle stage 0 outputs game_x = win_x+win_w-1 and game_y = win_y+win_h-1 with game_win=1, at the last screen pixel of that game pixel (the low s bits of h_cnt and v_cnt all 1).
  - Raster event: h_cnt == H_ACTIVE-1 && v_cnt == irq_line.
  - An event sets its status bit the next cycle. irq_ack bit clears the corresponding bit.
  - Set and ack in the same cycle: set wins.
  - irq is a registered level output.
  - irq_line >= V_TOTAL never fires.
  - win_w == 0 or win_h == 0: game_win never asserts and window-end never fires.
- frame_start is a registered pulse, high for 1 cycle.
- Reset (synchronous):
  - Counters, pipelines, irq_status, irq, frame_start, game_* and rgb all go to 0.
  - hsync/vsync go to the inactive level (!SYNC_POL).
  - Shadow registers reload from the inputs on the first cycle after reset.
  - Reset mid-frame restarts at h=0, v=0 with no spurious irq.

Test Plan:
1. Defaults, run 2 frames -> hsync period 800 cycles with 96-cycle low; vsync period 420000 cycles with 1600-cycle low; frame_start every 420000 cycles.
2. scale_mode=1, win=(16,16,256,224), layer0 key=12'h209 returns 12'h209, layer1 returns 12'h0F0 -> screen pixel (40,40) shows 12'h0F0 at t+4; screen (10,10) shows border_rgb; screen (700,10) shows 0.
3. All layers return their key -> bg_rgb inside the window; layer_en=0 on layer0 with a non-key colour -> layer1's colour.
4. Raster: irq_line=100, mask=2'b10 -> irq rises 1 cycle after h=639, v=100; irq_ack=2'b10 on the same cycle as the next set -> bit stays 1.
5. Window-end in 2x mode with the window above -> irq_status[0] sets after screen pixel (543,479); a scale_mode write mid-frame only takes effect at the next frame_start.
6. Assert rst at v=200 for 3 cycles -> all outputs at reset values; timing restarts at h=0, v=0; no irq_status bit set.
